// File: rtl/pzbcm_slicer_downsizer_pkg.sv
// Shared helpers for the slicer downsizer: beat-counter width calculation.
package pzbcm_slicer_downsizer_pkg;

  // A single-beat configuration still needs a 1-bit counter/num field.
  function automatic int calc_cw(input int ratio);
    return (ratio <= 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/pzbcm_slicer_downsizer_slicer_unit.sv
// Valid/ready register slice; FULL_BANDWIDTH=1 adds a skid entry so a beat can
// be taken every cycle while o_ready stays a registered signal.
module pzbcm_slicer_unit #(
  parameter int WIDTH          = 8,
  parameter int FULL_BANDWIDTH = 1,
  parameter int DISABLE_MBFF   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  if (WIDTH < 1) begin : g_bad_width
    $error("pzbcm_slicer_unit: WIDTH must be >= 1");
  end
  if ((DISABLE_MBFF < 0) || (DISABLE_MBFF > 1)) begin : g_bad_mbff
    $error("pzbcm_slicer_unit: DISABLE_MBFF must be 0 or 1");
  end

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push;
  logic             pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  always_comb begin
    o_ready      = (FULL_BANDWIDTH != 0) ? !skid_valid_q : !main_valid_q;
    push         = i_valid && o_ready;
    pop          = main_valid_q && i_ready;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    // The skid entry always drains into main first to keep beat order.
    if (pop || !main_valid_q) begin
      main_valid_d = skid_valid_q || push;
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        main_d = skid_q;
      end else if (push) begin
        main_d = i_data;
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_d       = i_data;
    end
  end

  assign o_valid = main_valid_q;
  assign o_data  = main_q;

endmodule

// File: rtl/pzbcm_slicer_downsizer.sv
// Wide-to-narrow valid/ready converter: emits each accepted word as n+1 beats,
// LSB beat first, reloading on the last beat so words stream without bubbles.
module pzbcm_slicer_downsizer
  import pzbcm_slicer_downsizer_pkg::*;
#(
  parameter int OUTPUT_WIDTH  = 8,
  parameter int RATIO         = 4,
  parameter int OUTPUT_SLICER = 0,
  parameter int DISABLE_MBFF  = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [OUTPUT_WIDTH*RATIO-1:0]    i_data,
  input  logic [calc_cw(RATIO)-1:0]        i_num_beats,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [OUTPUT_WIDTH-1:0]          o_data,
  output logic                             o_last
);

  localparam int CW = calc_cw(RATIO);
  localparam int IW = OUTPUT_WIDTH * RATIO;
  localparam logic [CW-1:0] MAX_NUM = CW'(RATIO - 1);

  if (RATIO < 1) begin : g_bad_ratio
    $error("pzbcm_slicer_downsizer: RATIO must be >= 1");
  end
  if (OUTPUT_WIDTH < 1) begin : g_bad_width
    $error("pzbcm_slicer_downsizer: OUTPUT_WIDTH must be >= 1");
  end

  logic                    valid_q, valid_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           num_q, num_d;
  logic [IW-1:0]           data_q, data_d;
  logic [CW:0]             num_ext;
  logic [CW-1:0]           num_clamped;
  logic                    in_accept;
  logic                    beat_accept;
  logic                    beat_valid;
  logic                    beat_last;
  logic                    beat_ready;
  logic [OUTPUT_WIDTH-1:0] beat_data;
  logic [OUTPUT_WIDTH-1:0] beats [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_beats
    assign beats[gi] = data_q[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
      num_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      data_q  <= data_d;
    end
  end

  // Out-of-range beat counts saturate; RATIO=1 therefore always sees 0.
  always_comb begin
    num_ext     = {1'b0, i_num_beats};
    num_clamped = (num_ext > {1'b0, MAX_NUM}) ? MAX_NUM : i_num_beats;
    in_accept   = i_valid && o_ready;
    beat_accept = valid_q && beat_ready;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    data_d      = data_q;
    if (in_accept) begin
      valid_d = 1'b1;
      cnt_d   = '0;
      num_d   = num_clamped;
      data_d  = i_data;
    end else if (beat_accept) begin
      if (beat_last) begin
        valid_d = 1'b0;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    beat_valid = valid_q;
    beat_last  = valid_q && (cnt_q == num_q);
    beat_data  = beats[cnt_q];
    o_ready    = !valid_q || (beat_ready && beat_last);
  end

  if (OUTPUT_SLICER != 0) begin : g_slicer
    logic [OUTPUT_WIDTH:0] slice_data;

    pzbcm_slicer_unit #(
      .WIDTH          (OUTPUT_WIDTH + 1),
      .FULL_BANDWIDTH (1),
      .DISABLE_MBFF   (DISABLE_MBFF)
    ) u_slicer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (beat_valid),
      .o_ready (beat_ready),
      .i_data  ({beat_last, beat_data}),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (slice_data)
    );

    assign {o_last, o_data} = slice_data;
  end else begin : g_direct
    assign o_valid    = beat_valid;
    assign o_data     = beat_data;
    assign o_last     = beat_last;
    assign beat_ready = i_ready;
  end

  if (RATIO > 1) begin : g_num_check
    assert property (@(posedge i_clk) disable iff (!i_rst_n)
                     in_accept |-> (num_ext <= {1'b0, MAX_NUM}))
      else $error("pzbcm_slicer_downsizer: i_num_beats exceeds RATIO-1");
  end

endmodule

// File: tb/tb_pzbcm_slicer_downsizer.sv
// Directed checks of the 32->8 downsizer, plus the output-slicer variant.
module tb_pzbcm_slicer_downsizer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_valid, a_ready;
  logic [31:0] a_data;
  logic [1:0]  a_num;
  logic        a_o_ready, a_o_valid, a_o_last;
  logic [7:0]  a_o_data;

  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic [1:0]  s_num;
  logic        s_o_ready, s_o_valid, s_o_last;
  logic [7:0]  s_o_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pzbcm_slicer_downsizer #(
    .OUTPUT_WIDTH(8), .RATIO(4), .OUTPUT_SLICER(0), .DISABLE_MBFF(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(a_valid), .o_ready(a_o_ready), .i_data(a_data), .i_num_beats(a_num),
    .o_valid(a_o_valid), .i_ready(a_ready), .o_data(a_o_data), .o_last(a_o_last)
  );

  pzbcm_slicer_downsizer #(
    .OUTPUT_WIDTH(8), .RATIO(4), .OUTPUT_SLICER(1), .DISABLE_MBFF(0)
  ) dut_s (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(s_valid), .o_ready(s_o_ready), .i_data(s_data), .i_num_beats(s_num),
    .o_valid(s_o_valid), .i_ready(s_ready), .o_data(s_o_data), .o_last(s_o_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for the falling edge, then checks the plain instance outputs.
  task automatic beat(input string tag, input logic v, input logic [7:0] d,
                      input logic l, input logic r);
    @(negedge clk);
    $display("step %s: valid=%0b data=0x%02h last=%0b ready=%0b",
             tag, a_o_valid, a_o_data, a_o_last, a_o_ready);
    chk({tag, ".valid"}, 32'(a_o_valid), 32'(v));
    chk({tag, ".data"},  32'(a_o_data),  32'(d));
    chk({tag, ".last"},  32'(a_o_last),  32'(l));
    chk({tag, ".ready"}, 32'(a_o_ready), 32'(r));
  endtask

  task automatic beat_s(input string tag, input logic v, input logic [7:0] d,
                        input logic l, input logic r);
    @(negedge clk);
    $display("step %s: valid=%0b data=0x%02h last=%0b ready=%0b",
             tag, s_o_valid, s_o_data, s_o_last, s_o_ready);
    chk({tag, ".valid"}, 32'(s_o_valid), 32'(v));
    chk({tag, ".data"},  32'(s_o_data),  32'(d));
    chk({tag, ".last"},  32'(s_o_last),  32'(l));
    chk({tag, ".ready"}, 32'(s_o_ready), 32'(r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a word offered: nothing may be captured.
    rst_n   = 1'b0;
    a_valid = 1'b1; a_data = 32'h4433_2211; a_num = 2'd3; a_ready = 1'b1;
    s_valid = 1'b0; s_data = 32'h0;         s_num = 2'd0; s_ready = 1'b1;
    beat("rst0", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle();
    beat("rst1", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle(); a_valid = 1'b0;
    beat("rst2", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle(); rst_n = 1'b1;
    beat("rel0", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle();
    beat("rel1", 1'b0, 8'h00, 1'b0, 1'b1);

    // Single full word.
    next_cycle(); a_valid = 1'b1; a_data = 32'h4433_2211; a_num = 2'd3;
    beat("s2.acc", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle(); a_valid = 1'b0;
    beat("s2.b0", 1'b1, 8'h11, 1'b0, 1'b0);
    next_cycle(); beat("s2.b1", 1'b1, 8'h22, 1'b0, 1'b0);
    next_cycle(); beat("s2.b2", 1'b1, 8'h33, 1'b0, 1'b0);
    next_cycle(); beat("s2.b3", 1'b1, 8'h44, 1'b1, 1'b1);
    next_cycle(); beat("s2.idle", 1'b0, 8'h11, 1'b0, 1'b1);

    // Back-to-back words with i_valid held.
    next_cycle(); a_valid = 1'b1; a_data = 32'h4433_2211; a_num = 2'd3;
    beat("s3.acc", 1'b0, 8'h11, 1'b0, 1'b1);
    next_cycle(); a_data = 32'hDDCC_BBAA;
    beat("s3.b0", 1'b1, 8'h11, 1'b0, 1'b0);
    next_cycle(); beat("s3.b1", 1'b1, 8'h22, 1'b0, 1'b0);
    next_cycle(); beat("s3.b2", 1'b1, 8'h33, 1'b0, 1'b0);
    next_cycle(); beat("s3.b3", 1'b1, 8'h44, 1'b1, 1'b1);
    next_cycle(); a_valid = 1'b0;
    beat("s3.b4", 1'b1, 8'hAA, 1'b0, 1'b0);
    next_cycle(); beat("s3.b5", 1'b1, 8'hBB, 1'b0, 1'b0);
    next_cycle(); beat("s3.b6", 1'b1, 8'hCC, 1'b0, 1'b0);
    next_cycle(); beat("s3.b7", 1'b1, 8'hDD, 1'b1, 1'b1);
    next_cycle(); beat("s3.idle", 1'b0, 8'hAA, 1'b0, 1'b1);

    // Partial word (2 beats), next word taken on its last beat.
    next_cycle(); a_valid = 1'b1; a_data = 32'h0000_2211; a_num = 2'd1;
    beat("s4.acc", 1'b0, 8'hAA, 1'b0, 1'b1);
    next_cycle(); a_data = 32'h4433_2211; a_num = 2'd3;
    beat("s4.b0", 1'b1, 8'h11, 1'b0, 1'b0);
    next_cycle(); beat("s4.b1", 1'b1, 8'h22, 1'b1, 1'b1);

    // Backpressure on the 0x22 beat of the follow-on word.
    next_cycle(); a_valid = 1'b0;
    beat("s5.b0", 1'b1, 8'h11, 1'b0, 1'b0);
    next_cycle(); a_ready = 1'b0;
    beat("s5.hold0", 1'b1, 8'h22, 1'b0, 1'b0);
    next_cycle(); beat("s5.hold1", 1'b1, 8'h22, 1'b0, 1'b0);
    next_cycle(); beat("s5.hold2", 1'b1, 8'h22, 1'b0, 1'b0);
    next_cycle(); a_ready = 1'b1;
    beat("s5.b1", 1'b1, 8'h22, 1'b0, 1'b0);
    next_cycle(); beat("s5.b2", 1'b1, 8'h33, 1'b0, 1'b0);
    next_cycle(); beat("s5.b3", 1'b1, 8'h44, 1'b1, 1'b1);
    next_cycle(); beat("s5.idle", 1'b0, 8'h11, 1'b0, 1'b1);

    // Single-beat word (num=0): first beat is also last.
    next_cycle(); a_valid = 1'b1; a_data = 32'h0000_00EE; a_num = 2'd0;
    beat("one.acc", 1'b0, 8'h11, 1'b0, 1'b1);
    next_cycle(); a_valid = 1'b0;
    beat("one.b0", 1'b1, 8'hEE, 1'b1, 1'b1);
    next_cycle(); beat("one.idle", 1'b0, 8'hEE, 1'b0, 1'b1);

    // Reset mid-word: asynchronous clear, no further beats.
    next_cycle(); a_valid = 1'b1; a_data = 32'h4433_2211; a_num = 2'd3;
    beat("s6.acc", 1'b0, 8'hEE, 1'b0, 1'b1);
    next_cycle(); a_valid = 1'b0;
    beat("s6.b0", 1'b1, 8'h11, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("s6.async.valid", 32'(a_o_valid), 32'd0);
    chk("s6.async.ready", 32'(a_o_ready), 32'd1);
    chk("s6.async.data",  32'(a_o_data),  32'h00);
    next_cycle(); beat("s6.rst", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle(); rst_n = 1'b1;
    beat("s6.rel0", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle(); beat("s6.rel1", 1'b0, 8'h00, 1'b0, 1'b1);

    // Slicer variant: same beats, one cycle later.
    next_cycle(); s_valid = 1'b1; s_data = 32'h4433_2211; s_num = 2'd3;
    beat_s("sl.acc", 1'b0, 8'h00, 1'b0, 1'b1);
    next_cycle(); s_valid = 1'b0;
    beat_s("sl.t1", 1'b0, 8'h00, 1'b0, 1'b0);
    next_cycle(); beat_s("sl.b0", 1'b1, 8'h11, 1'b0, 1'b0);
    next_cycle(); beat_s("sl.b1", 1'b1, 8'h22, 1'b0, 1'b0);
    next_cycle(); beat_s("sl.b2", 1'b1, 8'h33, 1'b0, 1'b1);
    next_cycle(); beat_s("sl.b3", 1'b1, 8'h44, 1'b1, 1'b1);
    next_cycle();
    @(negedge clk);
    chk("sl.idle.valid", 32'(s_o_valid), 32'd0);
    chk("sl.idle.ready", 32'(s_o_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
